clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//  Run/set controller for the hh:mm:ss clock counter. In RUN it generates the 1-per-TICK_DIV seconds enable.
//  In SET it pauses the counter and lets the user step hour/min/sec with two buttons.
//  Each change is written back through the counter's load strobes; the controller sits between board buttons and the counter.
// PARAMETERS
//  TICK_DIV    100_000_000  clock cycles per seconds tick (>=2)
//  REPEAT_DLY   50_000_000  cycles inc must be held before first auto-repeat (AUTO_REPEAT_EN only)
//  REPEAT_PER   10_000_000  cycles between subsequent auto-repeats (AUTO_REPEAT_EN only)
// PORTS
//  clock      in   1  system clock, all logic on posedge
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  btn_mode   in   1  mode button, debounced level, asynchronous to clock
//  btn_inc    in   1  increment button, debounced level, asynchronous to clock
//  cur_sec    in   6  counter seconds readback
//  cur_min    in   6  counter minutes readback
//  cur_hour   in   5  counter hours readback
//  tick_en    out  1  one-cycle seconds enable to counter
//  load_sec   out  1  one-cycle load strobe, seconds
//  load_min   out  1  one-cycle load strobe, minutes
//  load_hour  out  1  one-cycle load strobe, hours
//  load_data  out  6  value for the active strobe; hours use [4:0], [5]=0
//  set_mode   out  2  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
// BEHAVIOUR
//  - All outputs are registered. On reset assertion, immediately and asynchronously:
//    state=RUN; tick_en, load_*, load_data, set_mode = 0; prescaler and shadows = 0.
//  - Buttons: 2-flop synchroniser, then rising-edge detect -> 1-cycle pulse.
//    Pin edge to FSM action = 3 cycles; action to load strobe = +1 cycle.
//  - Prescaler (RUN only): count 0..TICK_DIV-1; tick_en=1 for the one cycle after count==TICK_DIV-1, then count wraps to 0.
//    In any SET state the count is held at 0 and tick_en=0.
//  - FSM: RUN -mode-> SET_HOUR -mode-> SET_MIN -mode-> SET_SEC -mode-> RUN. No other transitions.
//  - RUN->SET_HOUR: shadow_hour/min/sec <= cur_* in the same cycle the mode pulse is seen.
//  - inc pulse in SET_x: shadow_x <= (shadow_x==MAX_x) ? 0 : shadow_x+1, where MAX = 23/59/59.
//    Next cycle: load_x=1 and load_data=new shadow_x, for exactly one cycle.
//  - Shadow values above MAX (bad readback) wrap to 0 on the next inc.
//  - inc pulse in RUN is ignored.
//  - mode and inc pulses in the same cycle: mode wins, inc is dropped.
//  - At most one load_* is high in any cycle. load_* and tick_en are never high together.
//  - SET_SEC->RUN: no load is issued; the prescaler restarts at 0, so the first tick_en comes TICK_DIV cycles after the transition.
//  - Reset during any SET state returns to RUN with the counter untouched; no partial load is emitted.
// CONFIGURATION
//  - `CLOCK_SET_AUTO_REPEAT_EN defined: in SET_x, inc level held high for REPEAT_DLY cycles yields one inc pulse,
//    then one every REPEAT_PER cycles while held. Repeat counter clears on release or any state change.
//  - Not defined: only rising edges of btn_inc count; REPEAT_* are unused and no repeat counter is built.
// STRUCTURE
//  - Package clock_ctrl_pkg: state typedef (RUN, SET_HOUR, SET_MIN, SET_SEC with the set_mode encodings),
//    SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DATA_W=6.
//  - Sub-module btn_sync_edge (2-flop sync + rise pulse + synced level out), instanced for btn_mode and btn_inc.
//  - Top holds the FSM, prescaler, shadows, load mux and the optional repeat counter.
// TESTING (TICK_DIV=4, REPEAT_DLY=8, REPEAT_PER=3)
//  1. Release reset, RUN, no buttons -> tick_en pulses every 4th cycle; all load_* stay 0; set_mode=0.
//  2. cur=12:34:56, press mode -> set_mode=1, tick_en stops; 3 inc presses -> load_hour with load_data 13,14,15.
//  3. In SET_HOUR with shadow=23, inc -> load_hour with load_data=0. In SET_MIN with shadow=59, inc -> load_min with 0.
//  4. Mode and inc rising in the same cycle in SET_MIN -> state SET_SEC, no load strobe. Mode again -> RUN; first tick_en 4 cycles later.
//  5. Reset asserted mid-SET_SEC on the cycle after an inc -> all outputs 0 at once, no load_sec; after release, state=RUN.
//  6. AUTO_REPEAT_EN: hold inc 20 cycles in SET_SEC from shadow 0 -> first extra inc 8 cycles after the edge pulse,
//     then every 3 cycles; load_data steps 1,2,3...

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the clock run/set controller.
package clock_ctrl_pkg;

  localparam int DATA_W = 6;

  localparam logic [DATA_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [DATA_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [DATA_W-1:0] HOUR_MAX = 6'd23;

  // Encodings double as the set_mode output value.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, plus a one-cycle
// rising-edge pulse and the synchronised level.
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set controller for the hh:mm:ss counter: seconds prescaler, mode FSM,
// shadow registers and load strobes. Optional auto-repeat: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [5:0]        cur_sec,
  input  logic [5:0]        cur_min,
  input  logic [4:0]        cur_hour,
  output logic              tick_en,
  output logic              load_sec,
  output logic              load_min,
  output logic              load_hour,
  output logic [DATA_W-1:0] load_data,
  output logic [1:0]        set_mode
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t              state, state_nx, inc_fld, ld_sel_p0;
  logic                mode_rise, inc_rise, inc_lvl, unused_mode_lvl, inc_evt;
  logic [DATA_W-1:0]   shadow_hour, shadow_min, shadow_sec, ld_mux;
  logic [PS_W-1:0]     ps_cnt;

  function automatic logic [DATA_W-1:0] bump(input logic [DATA_W-1:0] v,
                                             input logic [DATA_W-1:0] mx);
    return (v >= mx) ? '0 : v + 1'b1;
  endfunction

  btn_sync_edge u_mode (
    .clock (clock),
    .reset (reset),
    .btn   (btn_mode),
    .level (unused_mode_lvl),
    .rise  (mode_rise)
  );

  btn_sync_edge u_inc (
    .clock (clock),
    .reset (reset),
    .btn   (btn_inc),
    .level (inc_lvl),
    .rise  (inc_rise)
  );

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_rpt, rep_fire;

  // First repeat after REPEAT_DLY held cycles, then every REPEAT_PER.
  always_comb begin
    rep_fire = 1'b0;
    if (inc_lvl && state != ST_RUN)
      rep_fire = rep_rpt ? (rep_cnt == REP_W'(REPEAT_PER))
                         : (rep_cnt == REP_W'(REPEAT_DLY));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
      rep_rpt <= 1'b0;
    end else if (!inc_lvl || state == ST_RUN || mode_rise) begin
      rep_cnt <= '0;
      rep_rpt <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt <= REP_W'(1);
      rep_rpt <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign inc_evt = inc_rise | rep_fire;
`else
  localparam int unused_rep_cfg = REPEAT_DLY + REPEAT_PER;
  logic unused_inc_lvl;
  assign unused_inc_lvl = inc_lvl;
  assign inc_evt        = inc_rise;
`endif

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode_rise) state_nx = state_t'(state + 2'd1);
  end

  // A mode pulse swallows any inc seen in the same cycle.
  always_comb begin
    inc_fld = ST_RUN;
    if (inc_evt && !mode_rise && state != ST_RUN) inc_fld = state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_hour <= '0;
      shadow_min  <= '0;
      shadow_sec  <= '0;
    end else if (mode_rise && state == ST_RUN) begin
      shadow_hour <= {1'b0, cur_hour};
      shadow_min  <= cur_min;
      shadow_sec  <= cur_sec;
    end else begin
      case (inc_fld)
        ST_SET_HOUR: shadow_hour <= bump(shadow_hour, HOUR_MAX);
        ST_SET_MIN:  shadow_min  <= bump(shadow_min, MIN_MAX);
        ST_SET_SEC:  shadow_sec  <= bump(shadow_sec, SEC_MAX);
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ld_sel_p0)
      ST_SET_HOUR: ld_mux = shadow_hour;
      ST_SET_MIN:  ld_mux = shadow_min;
      ST_SET_SEC:  ld_mux = shadow_sec;
      default:     ld_mux = '0;
    endcase
  end

  // Load stage: one cycle after the shadow update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_sel_p0 <= ST_RUN;
      load_hour <= 1'b0;
      load_min  <= 1'b0;
      load_sec  <= 1'b0;
      load_data <= '0;
    end else begin
      ld_sel_p0 <= inc_fld;
      load_hour <= (ld_sel_p0 == ST_SET_HOUR);
      load_min  <= (ld_sel_p0 == ST_SET_MIN);
      load_sec  <= (ld_sel_p0 == ST_SET_SEC);
      load_data <= ld_mux;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps_cnt  <= '0;
      tick_en <= 1'b0;
    end else if (state != ST_RUN) begin
      ps_cnt  <= '0;
      tick_en <= 1'b0;
    end else if (ps_cnt == PS_W'(TICK_DIV - 1)) begin
      ps_cnt  <= '0;
      tick_en <= 1'b1;
    end else begin
      ps_cnt  <= ps_cnt + 1'b1;
      tick_en <= 1'b0;
    end
  end

  assign set_mode = state;

endmodule
